// File: rtl/pwm_demod_pkg.sv
// Shared constants and state encoding for the PWM demodulator.
// Build option: PWM_DEMOD_SIGNED_EN selects two's-complement sample output.
package pwm_demod_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int AVG_LOG2_DEF = 2;
  localparam int WIN_LEN      = 1 << CNT_W_DEF;

  localparam logic [7:0] SAT_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_avg_ring.sv
// Boxcar ring of per-window duty values with a running sum; one push per window.
// Sum updates the clock after push; clear has priority over push.
module pwm_avg_ring #(
  parameter int DW       = 9,
  parameter int AVG_LOG2 = 2
) (
  input  logic                   clk_100m,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [DW-1:0]          duty,
  output logic [DW+AVG_LOG2-1:0] sum,
  output logic                   filled
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DW + AVG_LOG2;
  localparam logic [AVG_LOG2:0]   FULL    = (AVG_LOG2 + 1)'(DEPTH);
  localparam logic [AVG_LOG2:0]   CNT_ONE = (AVG_LOG2 + 1)'(1);
  localparam logic [AVG_LOG2-1:0] PTR_ONE = AVG_LOG2'(1);

  logic [DW-1:0]       ring [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   fill_cnt;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr   <= '0;
      sum      <= '0;
      fill_cnt <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr   <= '0;
      sum      <= '0;
      fill_cnt <= '0;
    end else if (push) begin
      ring[wr_ptr] <= duty;
      wr_ptr       <= wr_ptr + PTR_ONE;
      // Oldest slot leaves as the new window enters; the width holds DEPTH full windows.
      sum          <= sum + SUM_W'(duty) - SUM_W'(ring[wr_ptr]);
      if (fill_cnt != FULL) fill_cnt <= fill_cnt + CNT_ONE;
    end
  end

  assign filled = (fill_cnt == FULL);

endmodule

// File: rtl/pwm_demod.sv
// Recovers the modulating sample from a PWM stream: per-window high count, boxcar average, strobe.
// Strobe 2 clocks after the last pwm_q of a window is counted; no backpressure. Option: PWM_DEMOD_SIGNED_EN.
module pwm_demod
  import pwm_demod_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             pwm_i,
  output logic [7:0]       sample_o,
  output logic             sample_vld_o,
  output logic [CNT_W:0]   duty_o,
  output logic             filled_o
);

  localparam int SUM_W = CNT_W + 1 + AVG_LOG2;
  localparam logic [CNT_W-1:0] WIN_MAX = '1;
  localparam logic [CNT_W-1:0] WIN_ONE = CNT_W'(1);

  state_t           state;
  logic             pwm_q;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W:0]   high_cnt;
  logic [CNT_W:0]   pwm_ext;
  logic             push;
  logic [CNT_W:0]   duty_q;
  logic             avg_go;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] avg;
  logic             filled;
  logic [7:0]       avg_sat;
  logic [7:0]       out_val;

  assign pwm_ext = {{CNT_W{1'b0}}, pwm_q};

  pwm_avg_ring #(
    .DW       (CNT_W + 1),
    .AVG_LOG2 (AVG_LOG2)
  ) u_ring (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .clear    (!en_i),
    .push     (push),
    .duty     (duty_q),
    .sum      (sum),
    .filled   (filled)
  );

  // Only a full-high window (2^CNT_W) exceeds the 8-bit range.
  always_comb begin
    avg     = sum >> AVG_LOG2;
    avg_sat = (avg > SUM_W'(SAT_MAX)) ? SAT_MAX : avg[7:0];
`ifdef PWM_DEMOD_SIGNED_EN
    out_val = {~avg_sat[7], avg_sat[6:0]};
`else
    out_val = avg_sat;
`endif
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pwm_q        <= 1'b0;
      win_cnt      <= '0;
      high_cnt     <= '0;
      push         <= 1'b0;
      duty_q       <= '0;
      avg_go       <= 1'b0;
      duty_o       <= '0;
      sample_o     <= '0;
      sample_vld_o <= 1'b0;
      filled_o     <= 1'b0;
    end else begin
      pwm_q        <= pwm_i;
      push         <= 1'b0;
      avg_go       <= 1'b0;
      sample_vld_o <= 1'b0;
      if (!en_i) begin
        state    <= IDLE;
        win_cnt  <= '0;
        high_cnt <= '0;
        filled_o <= 1'b0;
      end else begin
        case (state)
          IDLE:    state <= FILL;
          FILL:    if (avg_go && filled) state <= RUN;
          RUN:     state <= RUN;
          default: state <= IDLE;
        endcase

        if (state != IDLE) begin
          // A sync restarts the window and throws away the partial count.
          if (sync_i) begin
            win_cnt  <= '0;
            high_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + WIN_ONE;
            if (win_cnt == WIN_MAX) begin
              high_cnt <= '0;
              duty_q   <= high_cnt + pwm_ext;
              push     <= 1'b1;
            end else begin
              high_cnt <= high_cnt + pwm_ext;
            end
          end
        end

        if (push) duty_o <= duty_q;
        avg_go <= push;

        if (avg_go && filled) begin
          sample_o     <= out_val;
          sample_vld_o <= 1'b1;
          filled_o     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/pwm_demod.md
Name: pwm_demod

Overview:
- Downstream stage of the sine-PWM generator; consumes its single-bit pwm output and recovers the modulating sample stream.
- Measures the high-time of pwm_i over each 256-clock carrier window.
- Smooths the per-window duty values with a boxcar average over 2^AVG_LOG2 windows.
- Emits an 8-bit sample with a one-cycle valid strobe, for loopback checking against the generator's data output and for driving a DAC/monitor.

Parameters:
- CNT_W, 8, window length is 2^CNT_W clocks (one carrier period).
- AVG_LOG2, 2, boxcar depth is 2^AVG_LOG2 windows (1..4 legal).

Ports:
- clk_100m  in  1  system clock.
- rst_n  in  1  reset.
- en_i  in  1  block enable; low holds the block in IDLE and clears state.
- sync_i  in  1  one-cycle pulse aligning the window start to the carrier start.
- pwm_i  in  1  PWM stream from the generator.
- sample_o  out  8  averaged recovered sample.
- sample_vld_o  out  1  one-cycle strobe, sample_o updated.
- duty_o  out  CNT_W+1  raw high count of the last completed window (0..256).
- filled_o  out  1  averaging buffer holds 2^AVG_LOG2 valid windows.

Behaviour:
- Reset: rst_n asynchronous, active-low, clock clk_100m.
  - All outputs 0; win_cnt, high_cnt, ring buffer, running sum and fill count all 0.
  - State = IDLE.
- Input stage: pwm_i registered once into pwm_q; all counting uses pwm_q.
- States: IDLE, FILL, RUN.
  - IDLE -> FILL when en_i=1.
  - FILL -> RUN after 2^AVG_LOG2 completed windows.
  - Any state -> IDLE when en_i=0. Entering IDLE clears counters, buffer, sum and filled_o; sample_o holds its last value.
- Window counting:
  - win_cnt (CNT_W bits) increments every clock in FILL/RUN and wraps 2^CNT_W-1 -> 0.
  - high_cnt (CNT_W+1 bits) adds pwm_q each clock.
  - On the wrap cycle: duty_raw = high_cnt + pwm_q (range 0..2^CNT_W); high_cnt is reloaded to 0.
- sync_i handling:
  - Takes priority over wrap: win_cnt and high_cnt forced to 0.
  - The partial window is discarded: no duty_raw, no buffer write.
  - Buffer contents and state are unchanged.
  - sync_i in IDLE is ignored.
- Averaging, the clock after duty_raw is produced:
  - Write duty_raw into the ring slot at wr_ptr; wr_ptr increments mod 2^AVG_LOG2.
  - sum <= sum + duty_raw - old_slot. sum is CNT_W+1+AVG_LOG2 bits, never overflows.
  - duty_o <= duty_raw.
- Output, the following clock:
  - avg = sum >> AVG_LOG2, saturated to 255 (only 256 saturates).
  - sample_o <= avg; sample_vld_o pulses for 1 cycle.
- Latency: sample_vld_o is high exactly 2 clocks after the edge at which the last pwm_q of a window is accumulated, i.e. 3 clocks after the corresponding pwm_i edge.
- Gating: in FILL, duty_o updates but sample_vld_o stays 0. The first strobe occurs on the window that completes the fill; filled_o rises together with that strobe.
- Simultaneous events:
  - en_i falling on a wrap cycle: the window is dropped.
  - sync_i and wrap together: sync wins.
  - Asynchronous reset mid-window: immediate clear, no strobe.

Optional Feature:
- Macro PWM_DEMOD_SIGNED_EN.
- Defined: sample_o is two's complement, avg - 128 (MSB inverted), matching the signed sine table format. Full duty gives 0x7F, zero duty gives 0x80, 50% gives 0x00. Reset value is still 0x00.
- Undefined: sample_o is unsigned 0..255 as above.

Decomposition:
- Package pwm_demod_pkg holds:
  - Default CNT_W and AVG_LOG2 constants.
  - WIN_LEN = 2^CNT_W.
  - State enum {IDLE, FILL, RUN}.
  - SAT_MAX = 8'd255.
- One sub-module, pwm_avg_ring:
  - Ring buffer, write pointer, running sum, fill counter.
  - Inputs: push, duty, clear. Outputs: sum, filled.

Test Plan:
- pwm_i=1 constantly, en_i=1, AVG_LOG2=2:
  - duty_o=256 each window, no strobe for the first 3 windows.
  - 4th window strobes sample_o=255; filled_o=1.
- pwm_i=0 constantly:
  - duty_o=0; sample_o=0 (0x80 with PWM_DEMOD_SIGNED_EN).
- 50% square wave (128 high / 128 low) aligned with sync_i:
  - duty_o=128, sample_o=128 (0x00 signed).
  - Strobe spacing exactly 256 clocks.
- Duty step 64 -> 192 after fill:
  - Successive samples 96, 128, 160, 192.
- sync_i pulse at win_cnt=100:
  - No strobe at the old boundary; next strobe 256+2 clocks after sync.
  - Buffer unaffected: sample continuity holds.
- en_i low for 10 cycles mid-RUN, then rst_n pulse mid-window:
  - filled_o=0 and a FILL restart of 4 windows before the next strobe.
  - Reset forces all outputs to 0 immediately.
